alu_writeback: RTL and testbench
================================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the register and ALU operand width.
REQ-002 The block SHALL have parameter REG_CNT, default 16, meaning the register count; the address width is 4.
REQ-003 Port clk SHALL be an input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-005 Port in_valid SHALL be an input, 1 bit: the ALU result bundle is valid this cycle.
REQ-006 Port in_ready SHALL be an output, 1 bit: the block accepts a bundle this cycle.
REQ-007 Port opcode SHALL be an input, 4 bits: the ALU opcode that produced the bundle.
REQ-008 Port dest SHALL be an input, 4 bits: the destination register index.
REQ-009 Port result SHALL be an input, 32 bits: the ALU result.
REQ-010 Port remainder SHALL be an input, 16 bits: the ALU remainder.
REQ-011 Port overflow SHALL be an input, 1 bit, active-low: 0 means the ALU flagged overflow.
REQ-012 Ports rd_addr_a and rd_addr_b SHALL be inputs, 4 bits each: the operand read addresses.
REQ-013 Ports rd_data_a and rd_data_b SHALL be outputs, 16 bits each: combinational read data.
REQ-014 Port ovf_err SHALL be an output, 1 bit: a one-cycle pulse when an accepted bundle carried overflow=0.
REQ-015 Port bad_op SHALL be an output, 1 bit: a one-cycle pulse when an accepted opcode is undefined (6, 10, 12-15).

Function
REQ-016 Transfer SHALL occur only when in_valid and in_ready are both 1 on a rising edge; in_ready SHALL be 1 only in state IDLE.
REQ-017 The FSM SHALL have three states: IDLE, WR_LO and WR_HI.
REQ-018 On transfer, IDLE SHALL capture opcode, dest, result, remainder and overflow into holding registers and go to WR_LO.
REQ-019 An undefined opcode SHALL be accepted, pulse bad_op in the next cycle, perform no write, and stay in IDLE.
REQ-020 WR_LO SHALL write result[15:0] to reg[dest], then go to WR_HI for opcode 4 (MUL) or 5 (DIV), otherwise to IDLE.
REQ-021 WR_HI SHALL write result[31:16] (MUL) or remainder (DIV) to reg[(dest+1) mod 16], then go to IDLE.
REQ-022 Register 0 SHALL read as 0 at all times, and writes to it SHALL be discarded; this includes a WR_HI write that wraps from 15 to 0.
REQ-023 Writes SHALL still occur when overflow=0; ovf_err SHALL pulse in the WR_LO cycle.
REQ-024 Reads SHALL be combinational; a read of the register being written that cycle SHALL return the old value, and the new value SHALL be visible the following cycle.
REQ-025 Throughput SHALL be one bundle per 2 cycles (single-word) or per 3 cycles (MUL/DIV).
REQ-026 Inputs SHALL be ignored while in_ready=0; the upstream holds the bundle stable until transfer.

Reset
REQ-027 reset SHALL force, asynchronously: FSM to IDLE, all registers to 0, holding registers to 0, ovf_err=0, bad_op=0 and in_ready=1 once released.
REQ-028 A reset asserted in WR_LO or WR_HI SHALL abort the pending write, so that no partial write survives.

Configuration
REQ-029 With macro ALU_WB_STATUS_EN defined, the block SHALL add output status[2:0] = {N,Z,V}, updated on each WR_LO: N=result[15], Z=(result[15:0]==0), V sticky-set by overflow=0 and cleared only by reset.
REQ-030 Without ALU_WB_STATUS_EN, the block SHALL have no status port and no flag logic.

Structure
REQ-031 A shared package alu_pkg SHALL hold the opcode constants (ADD=0, SUB=1, AND=2, OR=3, MUL=4, DIV=5, SHL=7, SHR=8, ROL=9, ROR=11), the FSM state typedef and DATA_W.
REQ-032 The block SHALL contain one sub-module, regfile_2r1w: 16x16, two asynchronous read ports, one synchronous write port, with R0 hardwired to zero.

Verification
REQ-033 ADD with dest=3 and result=0x0000_0007 -> reg3=0x0007 two edges after transfer; in_ready low for one cycle.
REQ-034 MUL with dest=5 and result=0x0001_86A0 -> reg5=0x86A0, then reg6=0x0001; in_ready low for two cycles.
REQ-035 DIV with dest=15, result=3 and remainder=2 -> reg15=0x0003; the wrap write to reg0 is discarded and reg0 reads 0.
REQ-036 SUB with overflow=0 and dest=2 -> reg2 written and ovf_err pulses exactly once; with ALU_WB_STATUS_EN, V=1 persists.
REQ-037 opcode=12 -> bad_op pulses, no register changes, and in_ready stays 1.
REQ-038 reset asserted during WR_HI of a MUL -> all registers read 0 and the FSM is in IDLE immediately after reset.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and default widths for the ALU
// writeback stage and its register file.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_MUL = 4'd4;
  localparam logic [3:0] OP_DIV = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_ROR = 4'd11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wb_state_e;

  function automatic logic op_is_defined(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL,
      OP_DIV, OP_SHL, OP_SHR, OP_ROL, OP_ROR: op_is_defined = 1'b1;
      default:                                op_is_defined = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file with two asynchronous read ports and one synchronous write
// port; entry 0 is hardwired to zero and swallows writes.
module regfile_2r1w #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 16,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem_q [REG_CNT];

  // NOTE: the array is reset on purpose -- a reset mid-writeback must leave
  // every architectural register at zero, which rules out a plain RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_CNT; i++) mem_q[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Same-cycle reads see the pre-write contents since the array only moves on the edge.
  assign rdata_a = (raddr_a == '0) ? '0 : mem_q[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem_q[raddr_b];

endmodule

// File: rtl/alu_writeback.sv
// ALU result writeback: accepts one result bundle, writes one or two words to
// the register file. Optional {N,Z,V} status output under ALU_WB_STATUS_EN.
module alu_writeback #(
  parameter int DATA_W  = alu_pkg::DATA_W,
  parameter int REG_CNT = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   opcode,
  input  logic [alu_pkg::ADDR_W-1:0]   dest,
  input  logic [2*DATA_W-1:0]          result,
  input  logic [DATA_W-1:0]            remainder,
  input  logic                         overflow,
  input  logic [alu_pkg::ADDR_W-1:0]   rd_addr_a,
  input  logic [alu_pkg::ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]            rd_data_a,
  output logic [DATA_W-1:0]            rd_data_b,
`ifdef ALU_WB_STATUS_EN
  output logic [2:0]                   status,
`endif
  output logic                         ovf_err,
  output logic                         bad_op
);

  import alu_pkg::*;

  wb_state_e           state_q;
  logic [3:0]          opcode_q;
  logic [ADDR_W-1:0]   dest_q;
  logic [2*DATA_W-1:0] result_q;
  logic [DATA_W-1:0]   remainder_q;
  logic                overflow_q;
  logic                bad_op_q;

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [ADDR_W-1:0]   dest_hi;

  // NOTE: state and holding registers use non-blocking assignments so every
  // read in this block sees the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      opcode_q    <= '0;
      dest_q      <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      overflow_q  <= 1'b0;
      bad_op_q    <= 1'b0;
    end else begin
      bad_op_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            opcode_q    <= opcode;
            dest_q      <= dest;
            result_q    <= result;
            remainder_q <= remainder;
            overflow_q  <= overflow;
            if (op_is_defined(opcode)) state_q  <= WR_LO;
            else                       bad_op_q <= 1'b1;
          end
        end
        WR_LO:   state_q <= (opcode_q == OP_MUL || opcode_q == OP_DIV) ? WR_HI : IDLE;
        WR_HI:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The high word lands in the next register up, wrapping 15 -> 0.
  assign dest_hi = dest_q + 1'b1;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = dest_q;
    wr_data = result_q[DATA_W-1:0];
    case (state_q)
      WR_LO: wr_en = 1'b1;
      WR_HI: begin
        wr_en   = 1'b1;
        wr_addr = dest_hi;
        wr_data = (opcode_q == OP_MUL) ? result_q[2*DATA_W-1:DATA_W] : remainder_q;
      end
      default: ;
    endcase
  end

  regfile_2r1w #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT),
    .ADDR_W  (ADDR_W)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (wr_en),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .raddr_a (rd_addr_a),
    .raddr_b (rd_addr_b),
    .rdata_a (rd_data_a),
    .rdata_b (rd_data_b)
  );

  assign in_ready = (state_q == IDLE);
  assign ovf_err  = (state_q == WR_LO) && !overflow_q;
  assign bad_op   = bad_op_q;

`ifdef ALU_WB_STATUS_EN
  logic [2:0] status_q;

  // V is sticky; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_q <= '0;
    end else if (state_q == WR_LO) begin
      status_q <= {result_q[DATA_W-1], (result_q[DATA_W-1:0] == '0), status_q[0] | !overflow_q};
    end
  end

  assign status = status_q;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Randomized scoreboard bench for alu_writeback; the driver updates a register
// model and queues expectations, a monitor checks them as the DUT completes.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = '0;
  logic [3:0]  dest = '0;
  logic [31:0] result = '0;
  logic [15:0] remainder = '0;
  logic        overflow = 1'b1;
  logic [3:0]  rd_addr_a = '0;
  logic [3:0]  rd_addr_b = '0;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        ovf_err;
  logic        bad_op;
`ifdef ALU_WB_STATUS_EN
  logic [2:0]  status;
`endif

  alu_writeback dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .dest      (dest),
    .result    (result),
    .remainder (remainder),
    .overflow  (overflow),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
`ifdef ALU_WB_STATUS_EN
    .status    (status),
`endif
    .ovf_err   (ovf_err),
    .bad_op    (bad_op)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit          bad;
    bit          wide;
    bit          ovf;
    logic [3:0]  dest;
    logic [3:0]  dest_hi;
    logic [15:0] old_lo;
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
    logic [2:0]  exp_status;
  } item_t;

  item_t       sb_q[$];
  logic [15:0] model_regs [16];
  logic [2:0]  model_status;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit op_defined_ref(input logic [3:0] op);
    return !(op == 4'd6 || op == 4'd10 || op >= 4'd12);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_regs[i] = '0;
    model_status = '0;
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] d, input logic [31:0] res,
                      input logic [15:0] rem, input logic ovf_n);
    item_t it;
    int    waited;
    @(negedge clk);
    opcode = op; dest = d; result = res; remainder = rem; overflow = ovf_n; in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    it.bad     = !op_defined_ref(op);
    it.wide    = (op == 4'd4 || op == 4'd5);
    it.ovf     = !it.bad && !ovf_n;
    it.dest    = d;
    it.dest_hi = 4'((int'(d) + 1) % 16);
    it.old_lo  = model_regs[d];
    if (!it.bad) begin
      if (d != 0) model_regs[d] = res[15:0];
      if (it.wide && it.dest_hi != 0) model_regs[it.dest_hi] = (op == 4'd4) ? res[31:16] : rem;
      model_status = {res[15], res[15:0] == 16'h0, model_status[0] | !ovf_n};
    end
    it.exp_lo     = model_regs[d];
    it.exp_hi     = model_regs[it.dest_hi];
    it.exp_status = model_status;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    opcode    = 4'($urandom);
    dest      = 4'($urandom);
    result    = $urandom;
    remainder = 16'($urandom);
    overflow  = 1'($urandom);
  endtask

  // Monitor: owns the read ports and consumes scoreboard entries.
  initial begin : monitor
    item_t cur;
    item_t bi;
    bit    busy = 1'b0;
    bit    in_rst = 1'b1;
    int    low = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 1'b0;
        sb_q.delete();
        in_rst = 1'b1;
      end else if (in_rst) begin
        in_rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_ovf_err", 32'(ovf_err), 32'd0);
        check("reset_bad_op", 32'(bad_op), 32'd0);
`ifdef ALU_WB_STATUS_EN
        check("reset_status", 32'(status), 32'd0);
`endif
        for (int i = 0; i < 8; i++) begin
          rd_addr_a = 4'(i);
          rd_addr_b = 4'(i + 8);
          #1;
          check($sformatf("reset_reg%0d", i), 32'(rd_data_a), 32'd0);
          check($sformatf("reset_reg%0d", i + 8), 32'(rd_data_b), 32'd0);
        end
      end else begin
        if (bad_op) begin
          if (sb_q.size() == 0) begin
            check("bad_op_unexpected", 32'd1, 32'd0);
          end else begin
            bi = sb_q.pop_front();
            check("bad_op_expected", 32'(bi.bad), 32'd1);
            check("bad_op_in_ready", 32'(in_ready), 32'd1);
            check("bad_op_ovf_err", 32'(ovf_err), 32'd0);
            rd_addr_a = bi.dest;
            #1;
            check("bad_op_no_write", 32'(rd_data_a), 32'(bi.exp_lo));
          end
        end
        if (!in_ready) begin
          if (!busy) begin
            busy = 1'b1;
            low  = 1;
            if (sb_q.size() == 0) begin
              check("busy_unexpected", 32'd1, 32'd0);
              cur = '{default: '0};
            end else begin
              cur = sb_q.pop_front();
              check("accepted_defined_op", 32'(cur.bad), 32'd0);
              check("wr_lo_ovf_err", 32'(ovf_err), 32'(cur.ovf));
              rd_addr_a = cur.dest;
              #1;
              check("read_old_during_write", 32'(rd_data_a), 32'(cur.old_lo));
            end
          end else begin
            low++;
            check("wr_hi_ovf_err", 32'(ovf_err), 32'd0);
            if (low > 2) begin
              check("busy_cycles_bound", 32'(low), 32'd2);
              busy = 1'b0;
            end
          end
        end else if (busy) begin
          busy = 1'b0;
          check("busy_cycles", 32'(low), cur.wide ? 32'd2 : 32'd1);
          rd_addr_a = cur.dest;
          rd_addr_b = cur.dest_hi;
          #1;
          check("wr_lo_data", 32'(rd_data_a), 32'(cur.exp_lo));
          if (cur.wide) check("wr_hi_data", 32'(rd_data_b), 32'(cur.exp_hi));
          check("reg0_zero", 32'(cur.dest_hi == 0 ? rd_data_b : 16'h0), 32'd0);
`ifdef ALU_WB_STATUS_EN
          check("status", 32'(status), 32'(cur.exp_status));
`endif
        end else begin
          check("idle_ovf_err", 32'(ovf_err), 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [3:0]  op;
    logic [31:0] res;
    logic        ovf_n;
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);

    send(4'd0,  4'd3,  32'h0000_0007, 16'h1111, 1'b1);  // ADD
    send(4'd4,  4'd5,  32'h0001_86A0, 16'h2222, 1'b1);  // MUL
    send(4'd5,  4'd15, 32'h0000_0003, 16'h0002, 1'b1);  // DIV wrapping into reg0
    send(4'd1,  4'd2,  32'h0000_8000, 16'h0000, 1'b0);  // SUB with overflow
    send(4'd12, 4'd3,  32'h0000_BEEF, 16'h0000, 1'b1);  // undefined opcode
    send(4'd3,  4'd0,  32'h0000_FFFF, 16'h0000, 1'b1);  // write to reg0 discarded
    send(4'd2,  4'd7,  32'h0000_0000, 16'h0000, 1'b1);  // zero result

    // Reset landing in WR_HI of a MUL must wipe everything.
    send(4'd4, 4'd8, 32'h1234_5678, 16'h0000, 1'b1);
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(4, 5));
      res = $urandom;
      if ($urandom_range(0, 7) == 0) res[15:0] = 16'h0;
      ovf_n = op_defined_ref(op) ? ($urandom_range(0, 5) != 0) : 1'b1;
      send(op, 4'($urandom), res, 16'($urandom), ovf_n);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(posedge clk);
    #5;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
